// File: rtl/lcd_display_sysid_checker.sv
// lcd_display_sysid_checker
//
// Avalon-MM read sequencer for the system-ID slave. After reset (optionally)
// or on a start pulse it reads the ID word (address 0) and then the timestamp
// word (address 1), and compares each against its build-time expected value.
// Results are held for the LCD status logic and for software until the next
// check starts.
//
// Ports
//   clock            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   start            one-cycle check request, ignored while a check runs
//   avm_address      word select: 0 = ID, 1 = timestamp
//   avm_read         read strobe
//   avm_waitrequest  slave stall
//   avm_readdata     slave read data
//   busy             check in progress
//   done             one-cycle pulse when a check completes or aborts
//   id_ok / ts_ok    captured word matched its expected value
//   timeout          last check was aborted on a stall
//   id_value         last captured ID word
//   ts_value         last captured timestamp word
//
// State   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for start (or the automatic post-reset check)
// RD_ID   | read strobe on address 0
// LAT_ID  | read latency wait for the ID word; also the mandatory gap
//         | between reads when the slave has zero latency
// RD_TS   | read strobe on address 1
// LAT_TS  | read latency wait for the timestamp word
// FIN     | one-cycle done pulse, result flags valid

module lcd_display_sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1429741001,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          AUTO_START         = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ID,
        S_LAT_ID,
        S_RD_TS,
        S_LAT_TS,
        S_FIN
    } state_t;

    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam bit          HAS_LAT    = (READ_LATENCY > 0);
    localparam logic [1:0]  LAT_LOAD   = HAS_LAT ? 2'(READ_LATENCY - 1) : 2'd0;

    state_t      r_state,     w_state;
    logic [15:0] r_stall_cnt, w_stall_cnt;
    logic [1:0]  r_lat_cnt,   w_lat_cnt;
    logic        r_auto_pend, w_auto_pend;
    logic [31:0] r_id_value,  w_id_value;
    logic [31:0] r_ts_value,  w_ts_value;
    logic        r_id_ok,     w_id_ok;
    logic        r_ts_ok,     w_ts_ok;
    logic        r_timeout,   w_timeout;
    logic        w_accept;
    logic        w_stall;

    // Strobe and address decode straight from the state register so an
    // asynchronous reset removes the read strobe immediately.
    assign avm_read    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
    assign avm_address = (r_state == S_RD_TS);
    assign busy        = (r_state != S_IDLE) && (r_state != S_FIN);
    assign done        = (r_state == S_FIN);
    assign id_ok       = r_id_ok;
    assign ts_ok       = r_ts_ok;
    assign timeout     = r_timeout;
    assign id_value    = r_id_value;
    assign ts_value    = r_ts_value;

    assign w_accept = avm_read && !avm_waitrequest;
    assign w_stall  = avm_read && avm_waitrequest;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_stall_cnt <= '0;
            r_lat_cnt   <= '0;
            r_auto_pend <= (AUTO_START != 0);
            r_id_value  <= '0;
            r_ts_value  <= '0;
            r_id_ok     <= 1'b0;
            r_ts_ok     <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_stall_cnt <= w_stall_cnt;
            r_lat_cnt   <= w_lat_cnt;
            r_auto_pend <= w_auto_pend;
            r_id_value  <= w_id_value;
            r_ts_value  <= w_ts_value;
            r_id_ok     <= w_id_ok;
            r_ts_ok     <= w_ts_ok;
            r_timeout   <= w_timeout;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_stall_cnt = r_stall_cnt;
        w_lat_cnt   = r_lat_cnt;
        w_auto_pend = r_auto_pend;
        w_id_value  = r_id_value;
        w_ts_value  = r_ts_value;
        w_id_ok     = r_id_ok;
        w_ts_ok     = r_ts_ok;
        w_timeout   = r_timeout;

        case (r_state)
            S_IDLE: begin
                if (start || r_auto_pend) begin
                    w_state     = S_RD_ID;
                    w_auto_pend = 1'b0;
                    w_stall_cnt = '0;
                    w_id_ok     = 1'b0;
                    w_ts_ok     = 1'b0;
                    w_timeout   = 1'b0;
                end
            end
            S_RD_ID, S_RD_TS: begin
                if (w_accept) begin
                    w_stall_cnt = '0;
                    w_lat_cnt   = LAT_LOAD;
                    if (r_state == S_RD_ID) begin
                        // Zero latency still passes through LAT_ID for one
                        // cycle so the strobe is low between the two reads.
                        w_state = S_LAT_ID;
                        if (!HAS_LAT) begin
                            w_id_value = avm_readdata;
                        end
                    end else if (HAS_LAT) begin
                        w_state = S_LAT_TS;
                    end else begin
                        w_ts_value = avm_readdata;
                        w_state    = S_FIN;
                    end
                end else if (w_stall) begin
                    w_stall_cnt = r_stall_cnt + 16'd1;
                    if (r_stall_cnt == STALL_LAST) begin
                        w_timeout = 1'b1;
                        w_state   = S_FIN;
                    end
                end
            end
            S_LAT_ID: begin
                if (r_lat_cnt == 2'd0) begin
                    if (HAS_LAT) begin
                        w_id_value = avm_readdata;
                    end
                    w_state = S_RD_TS;
                end else begin
                    w_lat_cnt = r_lat_cnt - 2'd1;
                end
            end
            S_LAT_TS: begin
                if (r_lat_cnt == 2'd0) begin
                    w_ts_value = avm_readdata;
                    w_state    = S_FIN;
                end else begin
                    w_lat_cnt = r_lat_cnt - 2'd1;
                end
            end
            S_FIN: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        // Flags are evaluated on the way into FIN against the values that
        // will be held there, so they are already valid during the done pulse.
        if ((w_state == S_FIN) && (r_state != S_FIN)) begin
            w_id_ok = !w_timeout && (w_id_value == EXPECTED_ID);
            w_ts_ok = !w_timeout && (w_ts_value == EXPECTED_TIMESTAMP);
        end
    end

endmodule
